otter_pc_sequencer: RTL and testbench

Multicycle fetch/next-PC sequencer that drives the program-counter register's PC_RST, PC_WRITE and PC_DIN inputs, and reads back PC_COUNT.
- Fetches each instruction from instruction memory with a req/valid handshake and issues it to execute.
- Waits for execute completion, then selects the next PC: trap vector, MEPC return, branch/jump target or PC+4.
- Sits between the PC register, instruction memory and the datapath control unit.

---
 rtl/otter_pc_sequencer.sv | 226 ++++++++++++++++++++++
 tb/tb_otter_pc_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/otter_pc_sequencer.sv
// otter_pc_sequencer
// Multicycle fetch / next-PC sequencer for the OTTER core. It drives the
// program-counter register through PC_RST, PC_WRITE and PC_DIN, and reads
// back PC_COUNT. Each instruction is fetched over a req/valid handshake and
// issued to execute. After execute completes, the sequencer selects the next
// PC from the trap vector, the MEPC return, a branch/jump target or PC+PC_INC.
//
// State sequence: INIT -> FETCH -> ISSUE -> EXEC -> UPDATE -> FETCH ...
//
// Handshake: a fetch transfer happens on a rising edge where IMEM_REQ and
// IMEM_VALID are both high. IMEM_REQ and IMEM_ADDR stay stable until that
// edge, except for the one-cycle request drop that follows a FETCH_ERR.
// IMEM_VALID is ignored while IMEM_REQ is low.
//
// Ports:
//   clk         rising-edge clock
//   RST_N       asynchronous active-low reset
//   PC_COUNT    current PC from the PC register
//   PC_RST      synchronous clear to the PC register (one cycle after reset)
//   PC_WRITE    PC load enable (one cycle per instruction)
//   PC_DIN      next PC value
//   IMEM_REQ    fetch request
//   IMEM_ADDR   fetch address
//   IMEM_VALID  fetch data valid
//   IMEM_RDATA  fetched instruction
//   IR          captured instruction
//   IR_VALID    one-cycle issue pulse
//   EXEC_DONE   execute finished; redirect inputs are valid (sampled in EXEC only)
//   BR_TAKEN    branch/jump taken
//   BR_TARGET   branch/jump target
//   MRET        return-from-trap
//   MEPC        trap return address
//   INTR        level interrupt request
//   INTR_EN     global interrupt enable
//   MTVEC       trap vector
//   INTR_ACK    one-cycle trap-taken pulse
//   MEPC_WE     MEPC write strobe
//   MEPC_DATA   address to save in MEPC
//   FETCH_ERR   one-cycle fetch timeout pulse
//
// All outputs are registered. The internal 'state' signal is the FSM state
// and can be observed hierarchically.
module otter_pc_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned PC_INC         = 4
) (
    input  logic        clk,
    input  logic        RST_N,
    input  logic [31:0] PC_COUNT,
    output logic        PC_RST,
    output logic        PC_WRITE,
    output logic [31:0] PC_DIN,
    output logic        IMEM_REQ,
    output logic [31:0] IMEM_ADDR,
    input  logic        IMEM_VALID,
    input  logic [31:0] IMEM_RDATA,
    output logic [31:0] IR,
    output logic        IR_VALID,
    input  logic        EXEC_DONE,
    input  logic        BR_TAKEN,
    input  logic [31:0] BR_TARGET,
    input  logic        MRET,
    input  logic [31:0] MEPC,
    input  logic        INTR,
    input  logic        INTR_EN,
    input  logic [31:0] MTVEC,
    output logic        INTR_ACK,
    output logic        MEPC_WE,
    output logic [31:0] MEPC_DATA,
    output logic        FETCH_ERR
);

    typedef enum logic [2:0] {
        INIT   = 3'd0,
        FETCH  = 3'd1,
        ISSUE  = 3'd2,
        EXEC   = 3'd3,
        UPDATE = 3'd4
    } state_t;

    localparam logic [7:0]  TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);
    localparam logic [31:0] PC_STEP     = 32'(PC_INC);
    localparam logic [31:0] ALIGN_MASK  = ~32'd3;

    state_t      state, state_d;
    logic [7:0]  cnt, cnt_d;
    logic [7:0]  cnt_inc;

    logic        pc_rst_d, pc_write_d, req_d, ir_valid_d;
    logic        ack_d, mepc_we_d, err_d;
    logic [31:0] pc_din_d, addr_d, ir_d, mepc_data_d;

    // Next PC ignoring any trap. It is used directly when there is no trap,
    // and it is the return address saved to MEPC when a trap is taken.
    logic [31:0] seq_target;
    logic        take_trap;

    assign cnt_inc   = cnt + 8'd1;
    assign take_trap = INTR & INTR_EN;

    always_comb begin
        if (MRET)
            seq_target = MEPC & ALIGN_MASK;
        else if (BR_TAKEN)
            seq_target = BR_TARGET & ALIGN_MASK;
        else
            seq_target = PC_COUNT + PC_STEP;
    end

    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        pc_rst_d    = 1'b0;
        pc_write_d  = 1'b0;
        pc_din_d    = PC_DIN;
        req_d       = IMEM_REQ;
        addr_d      = IMEM_ADDR;
        ir_d        = IR;
        ir_valid_d  = 1'b0;
        ack_d       = 1'b0;
        mepc_we_d   = 1'b0;
        mepc_data_d = MEPC_DATA;
        err_d       = 1'b0;

        case (state)
            INIT: begin
                // The first cycle after reset raises PC_RST. The next edge
                // clears the PC register and enters FETCH at address 0.
                if (!PC_RST) begin
                    pc_rst_d = 1'b1;
                end else begin
                    state_d = FETCH;
                    req_d   = 1'b1;
                    addr_d  = 32'd0;
                    cnt_d   = 8'd0;
                end
            end

            FETCH: begin
                if (!IMEM_REQ) begin
                    // Recovery cycle after a timeout: re-request the same address.
                    req_d = 1'b1;
                end else if (IMEM_VALID) begin
                    // A valid response takes priority over a timeout firing
                    // in the same cycle.
                    ir_d       = IMEM_RDATA;
                    ir_valid_d = 1'b1;
                    req_d      = 1'b0;
                    cnt_d      = 8'd0;
                    state_d    = ISSUE;
                end else if (cnt_inc == TIMEOUT_LIM) begin
                    err_d = 1'b1;
                    req_d = 1'b0;
                    cnt_d = 8'd0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            ISSUE: begin
                state_d = EXEC;
            end

            EXEC: begin
                if (EXEC_DONE) begin
                    state_d    = UPDATE;
                    pc_write_d = 1'b1;
                    if (take_trap) begin
                        pc_din_d    = MTVEC & ALIGN_MASK;
                        ack_d       = 1'b1;
                        mepc_we_d   = 1'b1;
                        mepc_data_d = seq_target;
                    end else begin
                        pc_din_d = seq_target;
                    end
                end
            end

            UPDATE: begin
                // The PC register loads PC_DIN on this edge, so the fetch
                // address equals the value being written.
                state_d = FETCH;
                req_d   = 1'b1;
                addr_d  = PC_DIN;
                cnt_d   = 8'd0;
            end

            default: begin
                state_d = INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            state     <= INIT;
            cnt       <= 8'd0;
            PC_RST    <= 1'b0;
            PC_WRITE  <= 1'b0;
            PC_DIN    <= 32'd0;
            IMEM_REQ  <= 1'b0;
            IMEM_ADDR <= 32'd0;
            IR        <= 32'd0;
            IR_VALID  <= 1'b0;
            INTR_ACK  <= 1'b0;
            MEPC_WE   <= 1'b0;
            MEPC_DATA <= 32'd0;
            FETCH_ERR <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            PC_RST    <= pc_rst_d;
            PC_WRITE  <= pc_write_d;
            PC_DIN    <= pc_din_d;
            IMEM_REQ  <= req_d;
            IMEM_ADDR <= addr_d;
            IR        <= ir_d;
            IR_VALID  <= ir_valid_d;
            INTR_ACK  <= ack_d;
            MEPC_WE   <= mepc_we_d;
            MEPC_DATA <= mepc_data_d;
            FETCH_ERR <= err_d;
        end
    end

endmodule

// File: tb/tb_otter_pc_sequencer.sv
// Directed testbench for otter_pc_sequencer. It uses a behavioural PC
// register and a zero-wait instruction memory that can withhold IMEM_VALID.
module tb_otter_pc_sequencer;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc_count;
    logic        pc_rst, pc_write;
    logic [31:0] pc_din;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic [31:0] ir;
    logic        ir_valid;
    logic        exec_done, br_taken, mret, intr, intr_en;
    logic [31:0] br_target, mepc, mtvec;
    logic        intr_ack, mepc_we, fetch_err;
    logic [31:0] mepc_data;

    logic        valid_en;
    int          n_checks = 0;
    int          n_pass   = 0;

    otter_pc_sequencer #(.TIMEOUT_CYCLES(4), .PC_INC(4)) dut (
        .clk        (clk),
        .RST_N      (rst_n),
        .PC_COUNT   (pc_count),
        .PC_RST     (pc_rst),
        .PC_WRITE   (pc_write),
        .PC_DIN     (pc_din),
        .IMEM_REQ   (imem_req),
        .IMEM_ADDR  (imem_addr),
        .IMEM_VALID (imem_valid),
        .IMEM_RDATA (imem_rdata),
        .IR         (ir),
        .IR_VALID   (ir_valid),
        .EXEC_DONE  (exec_done),
        .BR_TAKEN   (br_taken),
        .BR_TARGET  (br_target),
        .MRET       (mret),
        .MEPC       (mepc),
        .INTR       (intr),
        .INTR_EN    (intr_en),
        .MTVEC      (mtvec),
        .INTR_ACK   (intr_ack),
        .MEPC_WE    (mepc_we),
        .MEPC_DATA  (mepc_data),
        .FETCH_ERR  (fetch_err)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- environment models ----------------
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0013;
    endfunction

    // The PC register starts at a junk value so the PC_RST clear is visible.
    initial pc_count = 32'hDEAD_BEEC;
    always @(posedge clk) begin
        if (pc_rst)
            pc_count <= 32'd0;
        else if (pc_write)
            pc_count <= pc_din;
    end

    assign imem_valid = valid_en & imem_req;
    assign imem_rdata = mem_word(imem_addr);

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Waits (bounded) for a PC_WRITE pulse and checks the UPDATE outputs,
    // then checks that the pulse lasts one cycle. Ends in the next FETCH cycle.
    task automatic next_update(input string tag, input logic [31:0] exp_din,
                               input logic exp_ack, input logic [31:0] exp_mepc);
        int n = 0;
        while (!pc_write && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_write_seen"}, {31'd0, pc_write}, 32'd1);
        check({tag, "_din"}, pc_din, exp_din);
        check({tag, "_no_pc_rst"}, {31'd0, pc_rst}, 32'd0);
        check({tag, "_ack"}, {31'd0, intr_ack}, {31'd0, exp_ack});
        check({tag, "_mepc_we"}, {31'd0, mepc_we}, {31'd0, exp_ack});
        if (exp_ack)
            check({tag, "_mepc_data"}, mepc_data, exp_mepc);
        @(negedge clk);
        check({tag, "_write_1cyc"}, {31'd0, pc_write}, 32'd0);
        check({tag, "_ack_1cyc"}, {31'd0, intr_ack}, 32'd0);
        check({tag, "_fetch_addr"}, imem_addr, exp_din);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pc_rst"}, {31'd0, pc_rst}, 32'd0);
        check({tag, "_pc_write"}, {31'd0, pc_write}, 32'd0);
        check({tag, "_pc_din"}, pc_din, 32'd0);
        check({tag, "_req"}, {31'd0, imem_req}, 32'd0);
        check({tag, "_addr"}, imem_addr, 32'd0);
        check({tag, "_ir"}, ir, 32'd0);
        check({tag, "_ctl"}, {28'd0, ir_valid, intr_ack, mepc_we, fetch_err}, 32'd0);
        check({tag, "_mepc_data"}, mepc_data, 32'd0);
    endtask

    // Releases reset on a falling edge and checks the INIT pulse and the
    // first fetch at address 0. Ends in the first FETCH cycle.
    task automatic release_and_check_init(input string tag);
        rst_n = 1'b1;
        @(negedge clk);
        check({tag, "_pc_rst_hi"}, {31'd0, pc_rst}, 32'd1);
        check({tag, "_req_lo"}, {31'd0, imem_req}, 32'd0);
        @(negedge clk);
        check({tag, "_pc_rst_lo"}, {31'd0, pc_rst}, 32'd0);
        check({tag, "_req_hi"}, {31'd0, imem_req}, 32'd1);
        check({tag, "_addr0"}, imem_addr, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n     = 1'b0;
        valid_en  = 1'b1;
        exec_done = 1'b1;
        br_taken  = 1'b0;
        br_target = 32'd0;
        mret      = 1'b0;
        mepc      = 32'd0;
        intr      = 1'b0;
        intr_en   = 1'b0;
        mtvec     = 32'd0;

        repeat (3) @(negedge clk);
        check_all_zero("reset");

        // Reset release, zero-wait memory.
        release_and_check_init("init");
        @(negedge clk);
        check("issue_pulse", {31'd0, ir_valid}, 32'd1);
        check("issue_ir", ir, mem_word(32'd0));
        @(negedge clk);
        check("exec_ir_valid_lo", {31'd0, ir_valid}, 32'd0);
        check("exec_ir_hold", ir, mem_word(32'd0));
        next_update("seq0", 32'h4, 1'b0, 32'd0);
        next_update("seq1", 32'h8, 1'b0, 32'd0);

        // Branch target is word-aligned.
        br_taken  = 1'b1;
        br_target = 32'h0000_0103;
        next_update("br", 32'h100, 1'b0, 32'd0);

        // Trap beats branch; MEPC gets the branch target.
        intr      = 1'b1;
        intr_en   = 1'b1;
        br_target = 32'h200;
        mtvec     = 32'h80;
        next_update("trap", 32'h80, 1'b1, 32'h200);

        // Interrupt masked: branch wins, no ack.
        intr_en = 1'b0;
        next_update("masked", 32'h200, 1'b0, 32'd0);

        // MRET beats branch; MEPC is aligned.
        intr  = 1'b0;
        mret  = 1'b1;
        mepc  = 32'h45;
        next_update("mret", 32'h44, 1'b0, 32'd0);

        // Jump to the top of memory, then PC+4 wraps to zero.
        mret      = 1'b0;
        br_target = 32'hFFFF_FFFC;
        next_update("to_top", 32'hFFFF_FFFC, 1'b0, 32'd0);
        br_taken = 1'b0;
        next_update("wrap", 32'h0, 1'b0, 32'd0);

        // Timeout: IMEM_VALID withheld for 4 FETCH cycles.
        valid_en = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("to_wait%0d_req", i), {31'd0, imem_req}, 32'd1);
            check($sformatf("to_wait%0d_err", i), {31'd0, fetch_err}, 32'd0);
            @(negedge clk);
        end
        check("to_err_pulse", {31'd0, fetch_err}, 32'd1);
        check("to_err_req_lo", {31'd0, imem_req}, 32'd0);
        @(negedge clk);
        check("to_err_1cyc", {31'd0, fetch_err}, 32'd0);
        check("to_rereq", {31'd0, imem_req}, 32'd1);
        check("to_same_addr", imem_addr, 32'h0);

        // Valid on the 4th FETCH cycle wins over the timeout.
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        valid_en = 1'b1;
        @(negedge clk);
        check("late_no_err", {31'd0, fetch_err}, 32'd0);
        check("late_issue", {31'd0, ir_valid}, 32'd1);
        check("late_ir", ir, mem_word(32'd0));
        next_update("late", 32'h4, 1'b0, 32'd0);

        // Reset mid-FETCH, away from any clock edge.
        valid_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_fetch");
        valid_en = 1'b1;
        @(negedge clk);
        release_and_check_init("rel_fetch");
        next_update("after_rf", 32'h4, 1'b0, 32'd0);

        // Reset mid-UPDATE.
        begin
            int n = 0;
            while (!pc_write && n < 40) begin
                @(negedge clk);
                n++;
            end
            check("mid_upd_seen", {31'd0, pc_write}, 32'd1);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_update");
        @(negedge clk);
        release_and_check_init("rel_update");
        next_update("after_ru", 32'h4, 1'b0, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global time limit so the bench always ends on its own.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
